div_unit: RTL and testbench

//   Iterative 32-bit radix-2 restoring divider for DIV/DIVU in the EX stage.
//   It sits on the requester side of the pipeline stall protocol. While a

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 116 +++++++++++
 tb/tb_div_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// The EX stage drives the master side; div_unit implements the slave side.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                start_i;
  logic                signed_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                annul_i;
  logic                stallreq_exe;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  stallreq_exe, result_o, ready_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output stallreq_exe, result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU that stalls the pipeline while busy.
// Optional build macro: DIV_ZERO_FAST_EN (divide-by-zero bypasses the iteration loop).
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_END} state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_t              state;
  logic [CNT_W-1:0]    counter;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   divisor;
  logic                neg_q;
  logic                neg_r;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [DATA_W:0]     shifted;
  logic                no_borrow;
  logic [DATA_W-1:0]   rem_step;
  logic [DATA_W-1:0]   quo_step;

  function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign bus.stallreq_exe = bus.start_i & ~ready_q & ~bus.annul_i;
  assign bus.result_o     = result_q;
  assign bus.ready_o      = ready_q;

  // Operand magnitudes and one restoring step; quo shifts the dividend out
  // at the top while quotient bits enter at the bottom.
  always_comb begin
    abs_a     = (bus.signed_i && bus.opdata1_i[DATA_W-1]) ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    abs_b     = (bus.signed_i && bus.opdata2_i[DATA_W-1]) ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    shifted   = {rem, quo[DATA_W-1]};
    no_borrow = (shifted >= {1'b0, divisor});
    rem_step  = no_borrow ? (shifted[DATA_W-1:0] - divisor) : shifted[DATA_W-1:0];
    quo_step  = {quo[DATA_W-2:0], no_borrow};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      counter  <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            rem     <= '0;
            quo     <= abs_a;
            divisor <= abs_b;
            neg_q   <= bus.signed_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            neg_r   <= bus.signed_i & bus.opdata1_i[DATA_W-1];
            counter <= '0;
`ifdef DIV_ZERO_FAST_EN
            // A zero divisor makes every step subtract nothing: all-ones quotient, remainder = |a|.
            if (bus.opdata2_i == '0) begin
              result_q <= {sign_fix(abs_a, bus.signed_i & bus.opdata1_i[DATA_W-1]),
                           sign_fix({DATA_W{1'b1}}, bus.signed_i & bus.opdata1_i[DATA_W-1])};
              ready_q  <= 1'b1;
              state    <= S_END;
            end else begin
              state <= S_ON;
            end
`else
            state <= S_ON;
`endif
          end
        end

        S_ON: begin
          if (bus.annul_i || !bus.start_i) begin
            state <= S_IDLE;
          end else begin
            rem     <= rem_step;
            quo     <= quo_step;
            counter <= counter + 1'b1;
            if (counter == LAST_STEP) begin
              result_q <= {sign_fix(rem_step, neg_r), sign_fix(quo_step, neg_q)};
              ready_q  <= 1'b1;
              state    <= S_END;
            end
          end
        end

        S_END: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide by zero, annul, start drop, mid-op reset and back-to-back operation.
module tb_div_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  div_unit_if dif ();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT   = 1;
  localparam int ZERO_STALL = 1;
`else
  localparam int ZERO_LAT   = 33;
  localparam int ZERO_STALL = 33;
`endif

  // Presents one operation, scrambles the operands after the accept, and
  // reports the cycle of the ready pulse relative to the first start cycle.
  task automatic run_op(input bit keep, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stalls, output logic [63:0] res,
                        output logic rdy_after, output time t_rdy);
    int cyc;
    lat = -1; stalls = 0; res = 'x; rdy_after = 1'b0; t_rdy = 0; cyc = 0;
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = sgn; dif.opdata1_i = a; dif.opdata2_i = b; dif.annul_i = 1'b0;
    while (cyc < 100 && lat < 0) begin
      #1;
      if (dif.stallreq_exe) stalls++;
      if (dif.ready_o) begin
        lat = cyc; res = dif.result_o; t_rdy = $time;
      end else begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin
          dif.opdata1_i = ~a; dif.opdata2_i = b + 32'd1; dif.signed_i = ~sgn;
        end
      end
    end
    if (!keep) begin
      dif.start_i = 1'b0;
      @(negedge clk);
      #1;
      rdy_after = dif.ready_o;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (dif.ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready got %b expected 0", dif.ready_o); end
    n_checks++; if (dif.result_o !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_result got %h expected 0", dif.result_o); end
    n_checks++; if (dif.stallreq_exe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall got %b expected 0", dif.stallreq_exe); end
    rst = 1'b0;
  endtask

  task automatic test_divu();
    int lat, stalls; logic [63:0] res; logic ra; time t;
    run_op(1'b0, 1'b0, 32'd100, 32'd7, lat, stalls, res, ra, t);
    n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL divu_100_7_latency got %0d expected 33", lat); end
    n_checks++; if (stalls !== 33) begin n_fail++; $display("[TB] FAIL divu_100_7_stall_cycles got %0d expected 33", stalls); end
    n_checks++; if (res !== {32'd2, 32'd14}) begin n_fail++; $display("[TB] FAIL divu_100_7_result got %h expected %h", res, {32'd2, 32'd14}); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("[TB] FAIL divu_ready_one_cycle got %b expected 0", ra); end
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'h00010000, lat, stalls, res, ra, t);
    n_checks++; if (res !== {32'h0000FFFF, 32'h0000FFFF}) begin n_fail++; $display("[TB] FAIL divu_max_result got %h expected %h", res, {32'h0000FFFF, 32'h0000FFFF}); end
    run_op(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, lat, stalls, res, ra, t);
    n_checks++; if (res !== {32'h80000000, 32'd0}) begin n_fail++; $display("[TB] FAIL divu_big_divisor got %h expected %h", res, {32'h80000000, 32'd0}); end
  endtask

  task automatic test_signed();
    int lat, stalls; logic [63:0] res; logic ra; time t;
    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, lat, stalls, res, ra, t);
    n_checks++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_fail++; $display("[TB] FAIL div_m7_2 got %h expected %h", res, {32'hFFFFFFFF, 32'hFFFFFFFD}); end
    run_op(1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, lat, stalls, res, ra, t);
    n_checks++; if (res !== {32'd1, 32'hFFFFFFFD}) begin n_fail++; $display("[TB] FAIL div_7_m2 got %h expected %h", res, {32'd1, 32'hFFFFFFFD}); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL div_7_m2_latency got %0d expected 33", lat); end
  endtask

  task automatic test_div_zero();
    int lat, stalls; logic [63:0] res; logic ra; time t;
    run_op(1'b0, 1'b0, 32'd5, 32'd0, lat, stalls, res, ra, t);
    n_checks++; if (res !== {32'd5, 32'hFFFFFFFF}) begin n_fail++; $display("[TB] FAIL divu_5_0 got %h expected %h", res, {32'd5, 32'hFFFFFFFF}); end
    n_checks++; if (lat !== ZERO_LAT) begin n_fail++; $display("[TB] FAIL divu_5_0_latency got %0d expected %0d", lat, ZERO_LAT); end
    n_checks++; if (stalls !== ZERO_STALL) begin n_fail++; $display("[TB] FAIL divu_5_0_stall_cycles got %0d expected %0d", stalls, ZERO_STALL); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("[TB] FAIL divu_5_0_ready_one_cycle got %b expected 0", ra); end
    run_op(1'b0, 1'b1, 32'hFFFFFFFB, 32'd0, lat, stalls, res, ra, t);
    n_checks++; if (res !== {32'hFFFFFFFB, 32'd1}) begin n_fail++; $display("[TB] FAIL div_m5_0 got %h expected %h", res, {32'hFFFFFFFB, 32'd1}); end
    n_checks++; if (lat !== ZERO_LAT) begin n_fail++; $display("[TB] FAIL div_m5_0_latency got %0d expected %0d", lat, ZERO_LAT); end
  endtask

  task automatic test_annul();
    int lat, stalls; logic [63:0] res; logic ra; time t;
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd3; dif.annul_i = 1'b0;
    repeat (10) @(negedge clk);
    dif.annul_i = 1'b1;
    #1;
    n_checks++; if (dif.stallreq_exe !== 1'b0) begin n_fail++; $display("[TB] FAIL annul_stall got %b expected 0", dif.stallreq_exe); end
    n_checks++; if (dif.ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL annul_ready got %b expected 0", dif.ready_o); end
    run_op(1'b0, 1'b0, 32'd20, 32'd4, lat, stalls, res, ra, t);
    n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL annul_then_new_latency got %0d expected 33", lat); end
    n_checks++; if (res !== {32'd0, 32'd5}) begin n_fail++; $display("[TB] FAIL annul_then_new_result got %h expected %h", res, {32'd0, 32'd5}); end
  endtask

  task automatic test_start_drop();
    int lat, stalls; logic [63:0] res; logic ra; time t;
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd7; dif.annul_i = 1'b0;
    repeat (5) @(negedge clk);
    dif.start_i = 1'b0;
    run_op(1'b0, 1'b0, 32'd50, 32'd5, lat, stalls, res, ra, t);
    n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL start_drop_latency got %0d expected 33", lat); end
    n_checks++; if (res !== {32'd0, 32'd10}) begin n_fail++; $display("[TB] FAIL start_drop_result got %h expected %h", res, {32'd0, 32'd10}); end
  endtask

  task automatic test_reset_mid();
    int lat, stalls; logic [63:0] res; logic ra; time t;
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0; dif.opdata1_i = 32'd1000; dif.opdata2_i = 32'd7; dif.annul_i = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (dif.ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_ready got %b expected 0", dif.ready_o); end
    n_checks++; if (dif.result_o !== 64'd0) begin n_fail++; $display("[TB] FAIL mid_reset_result got %h expected 0", dif.result_o); end
    rst = 1'b0;
    dif.start_i = 1'b0;
    run_op(1'b0, 1'b0, 32'd9, 32'd3, lat, stalls, res, ra, t);
    n_checks++; if (lat !== 33) begin n_fail++; $display("[TB] FAIL after_reset_latency got %0d expected 33", lat); end
    n_checks++; if (res !== {32'd0, 32'd3}) begin n_fail++; $display("[TB] FAIL after_reset_result got %h expected %h", res, {32'd0, 32'd3}); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, st1, st2; logic [63:0] res1, res2; logic ra1, ra2; time t1, t2;
    run_op(1'b1, 1'b0, 32'd10, 32'd3, lat1, st1, res1, ra1, t1);
    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat2, st2, res2, ra2, t2);
    n_checks++; if (res1 !== {32'd1, 32'd3}) begin n_fail++; $display("[TB] FAIL b2b_first_result got %h expected %h", res1, {32'd1, 32'd3}); end
    n_checks++; if (res2 !== {32'd0, 32'h80000000}) begin n_fail++; $display("[TB] FAIL b2b_second_result got %h expected %h", res2, {32'd0, 32'h80000000}); end
    n_checks++; if (lat2 !== 33) begin n_fail++; $display("[TB] FAIL b2b_second_latency got %0d expected 33", lat2); end
    n_checks++; if ((t2 - t1) !== 340) begin n_fail++; $display("[TB] FAIL b2b_pulse_spacing got %0t expected 340", t2 - t1); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    dif.start_i = 1'b0; dif.signed_i = 1'b0; dif.opdata1_i = '0; dif.opdata2_i = '0; dif.annul_i = 1'b0;
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_annul();
    test_start_drop();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
